mc_ctrl_unit: RTL and testbench
===============================

# mc_ctrl_unit

Multi-cycle RV32I control unit: replaces the single-cycle combinational decoder with a registered decode and an FSM that sequences fetch, decode, execute, memory and writeback over a req/ack handshake to instruction and data memory. It sits between the IR/PC registers and the datapath. It drives the same control-signal encodings to the ALU, register file and memory muxes. It adds memory wait-state tolerance, a per-access timeout and a retired-instruction counter.

## Interface
- TO_CYC, default 16: cycles a memory request may wait for ack before fault.
- CNT_W, default 32: instret counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word; op = instr[6:0], func3 = instr[14:12]; sampled when ir_we is high.
- imem_req / imem_ack  out / in  1  instruction fetch handshake.
- dmem_req / dmem_ack  out / in  1  data access handshake.
- ir_we, pc_we  out  1  IR load strobe and PC update strobe.
- brnc, mem_t_reg, alu_src1, alu_src2, offset_src, jal_act, rd_in, reg_w  out  1  datapath controls.
- mem_r, mem_w  out  2  00 byte, 01 half, 10 word, 11 none.
- alu_op  out  3  ALU operation class.
- instret  out  CNT_W  retired instruction count.
- fault  out  1  sticky timeout or illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Decode table, registered in DECODE and held stable until the next DECODE. Fields are brnc, alu_op, alu_src1, alu_src2, offset_src, jal_act, rd_in:
  - LUI 0110111: 0, 000, 1, 1, 0, 0, 1.
  - AUIPC 0010111: 0, 000, 0, 1, 1, 0, 0.
  - JAL 1101111: 1, 010, 0, 1, 0, 1, 0.
  - JALR 1100111: 1, 100, 0, 1, 0, 1, 0.
  - BRANCH 1100011: 1, 001, 1, 0, 0, 0, 0.
  - LOAD 0000011: 0, 000, 1, 1, 1, 0, 0; also mem_t_reg=1.
  - STORE 0100011: 0, 000, 1, 1, 1, 0, 0.
  - OP-IMM 0010011: 0, 101, 1, 1, 0, 0, 0.
  - OP 0110011: 0, 011, 1, 0, 0, 0, 0.
- Load size from func3: 000/100 → 00, 001/101 → 01, 010 → 10, others → 11. Store size from func3: 000/001/010 → 00/01/10, others → 11.
  - Undefined func3 never latches a stale size.
- Unknown opcode decodes as a NOP: all controls 0, alu_op 000, sizes 11.
- Transitions:
  - FETCH → DECODE on imem_ack.
  - DECODE → EXEC.
  - EXEC → MEM for LOAD/STORE, else → WB.
  - MEM → WB on dmem_ack for LOAD; MEM → FETCH on dmem_ack for STORE.
  - WB → FETCH.
- Output gating:
  - mem_r / mem_w show the decoded size only in MEM; 11 otherwise.
  - reg_w is high only in WB, and only for opcodes with a register write (all but BRANCH and STORE).
- PC update: pc_we pulses for exactly one cycle per instruction, in WB, or in the MEM ack cycle for STORE.
- instret increments on each pc_we and wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to FETCH or MEM and counts while the request is unacked.
  - Reaching TO_CYC without ack → HALT with fault=1.
  - HALT is absorbing until rst; all requests and strobes are low.

## Timing
- Reset values:
  - state FETCH.
  - all strobes (imem_req, dmem_req, ir_we, pc_we, reg_w) 0.
  - mem_r / mem_w 11.
  - alu_op 000.
  - remaining 1-bit controls 0.
  - instret 0, fault 0.
- imem_req rises in the first cycle after rst deasserts. imem_req and dmem_req are held high until the ack cycle inclusive, and drop the cycle after.
- ir_we is high in the imem_ack cycle.
- An ack arriving in the same cycle as the request is accepted, giving zero wait states.
- Minimum latencies with zero-wait memory:
  - ALU / branch / jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
- Ack arriving in the cycle the counter reaches TO_CYC: the ack wins, no fault.
- Acks received outside FETCH or MEM are ignored.
- rst mid-instruction aborts it: no pc_we, no reg_w, instret unchanged.

## Configuration
- CU_ILLEGAL_TRAP_EN:
  - Defined: an unknown opcode, or LOAD/STORE with an undefined func3, sets fault and goes DECODE → HALT without retiring.
  - Undefined: such instructions execute as NOPs (pc_we in WB, instret increments, reg_w 0).

## Structure
- Shared package cu_pkg:
  - opcode localparams.
  - state enum.
  - alu_op class constants.
  - the size encodings 00/01/10 and MEM_NONE = 11.
- Sub-module cu_decode: purely combinational opcode/func3 → control bundle. The FSM wrapper registers its output in DECODE.

## Test plan
- Reset, then ADDI with zero-wait memory → imem_req in cycle 1; ir_we in cycle 1; reg_w and pc_we in cycle 4; alu_op=101; instret=1.
- LW with dmem_ack delayed 3 cycles → mem_r=10 held for 4 MEM cycles; mem_t_reg=1; reg_w in the following cycle; 8 cycles total.
- SH → mem_w=01 in MEM only; reg_w never asserted; pc_we in the ack cycle.
- BEQ then JAL → BEQ: brnc=1, reg_w=0. JAL: jal_act=1, alu_op=010, reg_w=1.
- imem_ack withheld for TO_CYC=16 cycles → fault=1 and HALT; ack in cycle 16 instead → no fault.
- Opcode 1111111 → with CU_ILLEGAL_TRAP_EN: fault, instret unchanged. Without it: NOP retires, instret+1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// ALU operation classes, memory size encodings and the decoded control bundle.
package cu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_BR   = 3'b001;
  localparam logic [2:0] ALU_JAL  = 3'b010;
  localparam logic [2:0] ALU_REG  = 3'b011;
  localparam logic [2:0] ALU_JALR = 3'b100;
  localparam logic [2:0] ALU_IMM  = 3'b101;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_NONE = 2'b11;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef struct packed {
    logic       brnc;
    logic       mem_t_reg;
    logic       alu_src1;
    logic       alu_src2;
    logic       offset_src;
    logic       jal_act;
    logic       rd_in;
    logic       reg_write;
    logic       is_load;
    logic       is_store;
    logic [2:0] alu_op;
    logic [1:0] mem_r;
    logic [1:0] mem_w;
  } ctrl_t;

  function automatic ctrl_t nop_ctrl();
    ctrl_t c;
    c       = '0;
    c.mem_r = MEM_NONE;
    c.mem_w = MEM_NONE;
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode/func3 to control-bundle decoder; illegal encodings
// (unknown opcode, undefined load/store func3) come out as a NOP bundle.
import cu_pkg::*;

module cu_decode (
  input  logic [6:0] op,
  input  logic [2:0] func3,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = nop_ctrl();
    illegal = 1'b0;
    case (op)
      OP_LUI: begin
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.rd_in     = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.alu_src2   = 1'b1;
        ctrl.offset_src = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_JAL: begin
        ctrl.brnc      = 1'b1;
        ctrl.alu_op    = ALU_JAL;
        ctrl.alu_src2  = 1'b1;
        ctrl.jal_act   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.brnc      = 1'b1;
        ctrl.alu_op    = ALU_JALR;
        ctrl.alu_src2  = 1'b1;
        ctrl.jal_act   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.brnc     = 1'b1;
        ctrl.alu_op   = ALU_BR;
        ctrl.alu_src1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_src1   = 1'b1;
        ctrl.alu_src2   = 1'b1;
        ctrl.offset_src = 1'b1;
        ctrl.mem_t_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.is_load    = 1'b1;
        case (func3)
          3'b000, 3'b100: ctrl.mem_r = MEM_BYTE;
          3'b001, 3'b101: ctrl.mem_r = MEM_HALF;
          3'b010:         ctrl.mem_r = MEM_WORD;
          default:        illegal    = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.alu_src1   = 1'b1;
        ctrl.alu_src2   = 1'b1;
        ctrl.offset_src = 1'b1;
        ctrl.is_store   = 1'b1;
        case (func3)
          3'b000:  ctrl.mem_w = MEM_BYTE;
          3'b001:  ctrl.mem_w = MEM_HALF;
          3'b010:  ctrl.mem_w = MEM_WORD;
          default: illegal    = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.alu_op    = ALU_IMM;
        ctrl.alu_src1  = 1'b1;
        ctrl.alu_src2  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_OP: begin
        ctrl.alu_op    = ALU_REG;
        ctrl.alu_src1  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // Replace the whole bundle so a bad func3 never leaves a partial size behind.
    if (illegal) ctrl = nop_ctrl();
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack
// memory handshakes, per-access timeout and instret. Option macro: CU_ILLEGAL_TRAP_EN.
import cu_pkg::*;

module mc_ctrl_unit #(
  parameter int TO_CYC = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             brnc,
  output logic             mem_t_reg,
  output logic             alu_src1,
  output logic             alu_src2,
  output logic             offset_src,
  output logic             jal_act,
  output logic             rd_in,
  output logic             reg_w,
  output logic [1:0]       mem_r,
  output logic [1:0]       mem_w,
  output logic [2:0]       alu_op,
  output logic [CNT_W-1:0] instret,
  output logic             fault
);

  localparam int TW = $clog2(TO_CYC + 1);

  state_t        state, nxt;
  ctrl_t         ctrl_q, dec;
  logic          dec_illegal;
  logic [6:0]    ir_op;
  logic [2:0]    ir_f3;
  logic [TW-1:0] to_cnt;
  logic          to_last, set_fault, run_q, hold;

  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  cu_decode u_dec (
    .op      (ir_op),
    .func3   (ir_f3),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

`ifndef CU_ILLEGAL_TRAP_EN
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

  assign brnc       = ctrl_q.brnc;
  assign mem_t_reg  = ctrl_q.mem_t_reg;
  assign alu_src1   = ctrl_q.alu_src1;
  assign alu_src2   = ctrl_q.alu_src2;
  assign offset_src = ctrl_q.offset_src;
  assign jal_act    = ctrl_q.jal_act;
  assign rd_in      = ctrl_q.rd_in;
  assign alu_op     = ctrl_q.alu_op;

  // run_q keeps every strobe low in reset and in the cycle rst deasserts.
  assign hold    = rst | ~run_q;
  assign to_last = (to_cnt == TW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_w     = 1'b0;
    mem_r     = MEM_NONE;
    mem_w     = MEM_NONE;
    set_fault = 1'b0;
    if (!hold) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we = 1'b1;
            nxt   = DECODE;
          end else if (to_last) begin
            nxt       = HALT;
            set_fault = 1'b1;
          end
        end
        DECODE: begin
          nxt = EXEC;
`ifdef CU_ILLEGAL_TRAP_EN
          if (dec_illegal) begin
            nxt       = HALT;
            set_fault = 1'b1;
          end
`endif
        end
        EXEC: nxt = (ctrl_q.is_load || ctrl_q.is_store) ? MEM : WB;
        MEM: begin
          dmem_req = 1'b1;
          mem_r    = ctrl_q.mem_r;
          mem_w    = ctrl_q.mem_w;
          if (dmem_ack) begin
            if (ctrl_q.is_store) begin
              pc_we = 1'b1;
              nxt   = FETCH;
            end else begin
              nxt = WB;
            end
          end else if (to_last) begin
            nxt       = HALT;
            set_fault = 1'b1;
          end
        end
        WB: begin
          pc_we = 1'b1;
          reg_w = ctrl_q.reg_write;
          nxt   = FETCH;
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      ir_op   <= '0;
      ir_f3   <= '0;
      ctrl_q  <= nop_ctrl();
      to_cnt  <= '0;
      instret <= '0;
      fault   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (ir_we) begin
        ir_op <= instr[6:0];
        ir_f3 <= instr[14:12];
      end
      if (state == DECODE) ctrl_q <= dec;
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) to_cnt <= to_cnt + TW'(1);
      else                                                     to_cnt <= '0;
      if (pc_we)     instret <= instret + CNT_W'(1);
      if (set_fault) fault   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: directed instructions against a wait-state memory responder.
module tb_mc_ctrl_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, dmem_req, ir_we, pc_we;
  logic        brnc, mem_t_reg, alu_src1, alu_src2, offset_src, jal_act, rd_in, reg_w;
  logic [1:0]  mem_r, mem_w;
  logic [2:0]  alu_op;
  logic [31:0] instret;
  logic        fault;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.TO_CYC(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we),
    .brnc(brnc), .mem_t_reg(mem_t_reg), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .offset_src(offset_src), .jal_act(jal_act), .rd_in(rd_in), .reg_w(reg_w),
    .mem_r(mem_r), .mem_w(mem_w), .alu_op(alu_op),
    .instret(instret), .fault(fault)
  );

  typedef struct {
    string name;
    int cycles, irwe, alu, br, jal, mtr, regw, memc, mr, mw, inmem, ibefore;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int imem_delay = 0;
  int dmem_delay = 0;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void fail(string nm, string msg);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, msg);
  endfunction

  function automatic exp_t mk(string n, int cyc, int irw, int alu, int br, int jl, int mt,
                              int rw, int mc, int mr, int mw, int im, int ib);
    exp_t e;
    e.name = n; e.cycles = cyc; e.irwe = irw; e.alu = alu; e.br = br; e.jal = jl;
    e.mtr = mt; e.regw = rw; e.memc = mc; e.mr = mr; e.mw = mw; e.inmem = im; e.ibefore = ib;
    return e;
  endfunction

  // Memory responder: ack after imem_delay / dmem_delay wait states of an asserted request.
  initial begin
    int iw = 0;
    int dw = 0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req) begin imem_ack = (iw == imem_delay); iw++; end
      else          begin imem_ack = 1'b0; iw = 0; end
      if (dmem_req) begin dmem_ack = (dw == dmem_delay); dw++; end
      else          begin dmem_ack = 1'b0; dw = 0; end
    end
  end

  // Monitor: tracks each instruction from imem_req rise and checks it at retirement.
  initial begin
    bit in_i = 1'b0;
    int cyc = 0, irc = 0, memc = 0, regwc = 0, gate = 0, mr = 3, mw = 3;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_i = 1'b0;
      end else begin
        if (!in_i && imem_req) begin
          in_i = 1'b1; cyc = 0; irc = 0; memc = 0; regwc = 0; gate = 0; mr = 3; mw = 3;
        end
        if (in_i) begin
          cyc++;
          if (ir_we && irc == 0) irc = cyc;
          if (dmem_req) begin memc++; mr = mem_r; mw = mem_w; end
          else if (mem_r != 2'b11 || mem_w != 2'b11) gate++;
          if (reg_w) regwc++;
          if (pc_we) begin
            if (sb.size() == 0) begin
              fail("retire", "pc_we with no instruction expected");
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk({e.name, ".cycles"},    cyc,          e.cycles);
              chk({e.name, ".ir_we_cyc"}, irc,          e.irwe);
              chk({e.name, ".alu_op"},    int'(alu_op), e.alu);
              chk({e.name, ".brnc"},      int'(brnc),   e.br);
              chk({e.name, ".jal_act"},   int'(jal_act), e.jal);
              chk({e.name, ".mem_t_reg"}, int'(mem_t_reg), e.mtr);
              chk({e.name, ".reg_w_cnt"}, regwc,        e.regw);
              chk({e.name, ".mem_cycles"}, memc,        e.memc);
              chk({e.name, ".mem_r"},     mr,           e.mr);
              chk({e.name, ".mem_w"},     mw,           e.mw);
              chk({e.name, ".pc_in_mem"}, int'(dmem_req), e.inmem);
              chk({e.name, ".size_gate"}, gate,         0);
              chk({e.name, ".instret"},   int'(instret), e.ibefore);
            end
            in_i = 1'b0;
          end
        end else if (pc_we || reg_w) begin
          fail("stray_strobe", "pc_we/reg_w outside an instruction");
        end
      end
    end
  end

  task automatic run(input logic [31:0] ins, input int id, input int dd, input exp_t e);
    int n;
    sb.push_back(e);
    instr      = ins;
    imem_delay = id;
    dmem_delay = dd;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pc_we) break;
      if (n >= 300) begin
        fail({e.name, ".retire_wait"}, "no pc_we within 300 cycles");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.imem_req", int'(imem_req), 0);
    chk("rst.dmem_req", int'(dmem_req), 0);
    chk("rst.ir_we",    int'(ir_we),    0);
    chk("rst.pc_we",    int'(pc_we),    0);
    chk("rst.reg_w",    int'(reg_w),    0);
    chk("rst.mem_r",    int'(mem_r),    3);
    chk("rst.mem_w",    int'(mem_w),    3);
    chk("rst.alu_op",   int'(alu_op),   0);
    chk("rst.brnc",     int'(brnc),     0);
    chk("rst.instret",  int'(instret),  0);
    chk("rst.fault",    int'(fault),    0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cycle0.imem_req", int'(imem_req), 0);

    run(32'h0050_0093, 0, 0, mk("addi", 4, 1, 5, 0, 0, 0, 1, 0, 3, 3, 0, 0));
    run(32'h0000_2103, 0, 3, mk("lw",   8, 1, 0, 0, 0, 1, 1, 4, 2, 3, 0, 1));
    run(32'h0020_1023, 0, 0, mk("sh",   4, 1, 0, 0, 0, 0, 0, 1, 3, 1, 1, 2));
    run(32'h0000_0063, 0, 0, mk("beq",  4, 1, 1, 1, 0, 0, 0, 0, 3, 3, 0, 3));
    run(32'h0000_00EF, 0, 0, mk("jal",  4, 1, 2, 1, 1, 0, 1, 0, 3, 3, 0, 4));
    run(32'h0000_0003, 2, 0, mk("lb",   7, 3, 0, 0, 0, 1, 1, 1, 0, 3, 0, 5));
    run(32'h0000_10B7, TO - 1, 0, mk("lui_late", 19, 16, 0, 0, 0, 0, 1, 0, 3, 3, 0, 6));
    chk("late_ack.fault", int'(fault), 0);

`ifdef CU_ILLEGAL_TRAP_EN
    instr      = 32'h0000_007F;
    imem_delay = 0;
    repeat (10) @(negedge clk);
    chk("trap.fault",    int'(fault),    1);
    chk("trap.instret",  int'(instret),  7);
    chk("trap.imem_req", int'(imem_req), 0);
`else
    run(32'h0000_007F, 0, 0, mk("illegal_nop", 4, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 7));
    run(32'h0000_3003, 0, 0, mk("lw_bad_f3",   4, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 8));
    imem_delay = 1000;
    @(negedge clk);
    chk("nop.instret", int'(instret), 9);
    chk("nop.fault",   int'(fault),   0);
`endif

    // Fetch timeout: ack withheld, fault must appear after exactly TO fetch cycles.
    @(posedge clk);
    #1;
    rst        = 1'b1;
    imem_delay = 1000;
    instr      = 32'h0050_0093;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (TO + 1) @(negedge clk);
    chk("to.fault_before", int'(fault),    0);
    chk("to.req_before",   int'(imem_req), 1);
    @(negedge clk);
    chk("to.fault",    int'(fault),    1);
    chk("to.req_halt", int'(imem_req), 0);
    chk("to.instret",  int'(instret),  0);
    repeat (5) @(negedge clk);
    chk("halt.fault",    int'(fault),    1);
    chk("halt.imem_req", int'(imem_req), 0);
    chk("halt.dmem_req", int'(dmem_req), 0);

    chk("scoreboard_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
